keypad_scan_reader: RTL and testbench

//  Scans a 4x4 key matrix by driving one column low at a time and reading the

---
 rtl/keypad_pkg.sv | 18 +
 rtl/keypad_col_driver.sv | 38 +++
 rtl/keypad_scan_reader.sv | 195 +++++++++++++++++++
 tb/tb_keypad_scan_reader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

endpackage

// File: rtl/keypad_col_driver.sv
// Column scan timing: slot counter, one-hot active-low column rotation,
// and the sample / frame-end strobes consumed by the keypad reader.
module keypad_col_driver
  import keypad_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  output logic [1:0] col_idx,
  output logic       sample,
  output logic       frame_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] slot_cnt;

  assign sample    = (slot_cnt == CW'(CLK_DIV - 1));
  assign frame_end = sample && (col_idx == 2'd3);

  // Count through each column slot and step to the next column on its last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      col_n    <= COL_RESET;
      col_idx  <= 2'd0;
    end else if (sample) begin
      slot_cnt <= '0;
      col_n    <= {col_n[2:0], col_n[3]};
      col_idx  <= col_idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/keypad_scan_reader.sv
// 4x4 keypad scanner: synchronizes the rows, assembles a full-matrix frame,
// debounces one key and hands off one event per press with valid/ready.
// Optional macro KEYPAD_MULTI_KEY_REJECT_EN: frames with more than one key
// down are treated as empty (ghost/chord rejection); otherwise the lowest
// {row,col} code wins.
module keypad_scan_reader
  import keypad_pkg::*;
#(
  parameter int CLK_DIV         = 50000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output key_code_t key_code,
  output logic      key_valid,
  input  logic      key_ready,
  output logic      key_held,
  output logic      overflow
);

  localparam int CNTW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [1:0]      col_idx;
  logic            sample;
  logic            frame_end;
  logic [3:0]      row_meta;
  logic [3:0]      row_sync;
  logic [15:0]     keys;
  logic [15:0]     frame_keys;
  logic            any_key;
  logic            multi_key;
  logic            has_key;
  key_code_t       code;
  state_t          state;
  key_code_t       cand;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_inc;
  logic            confirm;

  keypad_col_driver #(.CLK_DIV(CLK_DIV)) u_col (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_n     (col_n),
    .col_idx   (col_idx),
    .sample    (sample),
    .frame_end (frame_end)
  );

  // Two-flop synchronizer for the asynchronous, pulled-up row inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  // Current frame image: stored columns plus the column being sampled right now.
  always_comb begin
    frame_keys = keys;
    for (int r = 0; r < ROWS; r++) begin
      frame_keys[{2'(r), col_idx}] = ~row_sync[r];
    end
  end

  // Latch each column's rows into the frame image at its sample point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys <= '0;
    end else if (sample) begin
      keys <= frame_keys;
    end
  end

  // Priority-encode the frame: lowest set bit is the lowest {row,col} code.
  always_comb begin
    code = '0;
    for (int i = ROWS * COLS - 1; i >= 0; i--) begin
      if (frame_keys[i]) begin
        code = 4'(i);
      end
    end
  end

  assign any_key   = |frame_keys;
  assign multi_key = |(frame_keys & (frame_keys - 16'd1));
`ifdef KEYPAD_MULTI_KEY_REJECT_EN
  assign has_key   = any_key && !multi_key;
`else
  assign has_key   = any_key;
`endif

  assign cnt_inc = cnt + CNTW'(1);

  // A press is confirmed at a frame end that completes the debounce run.
  always_comb begin
    confirm = 1'b0;
    if (frame_end && has_key) begin
      if (state == IDLE && DEBOUNCE_FRAMES == 1) begin
        confirm = 1'b1;
      end else if (state == DEBOUNCE && code == cand && cnt_inc == CNTW'(DEBOUNCE_FRAMES)) begin
        confirm = 1'b1;
      end
    end
  end

  // Debounce FSM plus the event handshake, held flag and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (confirm) begin
        key_held <= 1'b1;
        if (key_valid && !key_ready) begin
          overflow <= 1'b1;
        end else begin
          key_code  <= code;
          key_valid <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end

      if (frame_end) begin
        case (state)
          IDLE: begin
            if (has_key) begin
              cand <= code;
              if (DEBOUNCE_FRAMES == 1) begin
                state <= PRESSED;
                cnt   <= '0;
              end else begin
                state <= DEBOUNCE;
                cnt   <= CNTW'(1);
              end
            end
          end
          DEBOUNCE: begin
            if (has_key && code == cand) begin
              if (cnt_inc == CNTW'(DEBOUNCE_FRAMES)) begin
                state <= PRESSED;
                cnt   <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          PRESSED: begin
            if (!has_key) begin
              if (DEBOUNCE_FRAMES == 1) begin
                state    <= IDLE;
                cnt      <= '0;
                key_held <= 1'b0;
              end else begin
                state <= RELEASE;
                cnt   <= CNTW'(1);
              end
            end
          end
          RELEASE: begin
            if (has_key) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt_inc == CNTW'(DEBOUNCE_FRAMES)) begin
              state    <= IDLE;
              cnt      <= '0;
              key_held <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_reader.sv
// Testbench for keypad_scan_reader: a simulated key matrix drives the rows
// from the column pattern; a frame-level behavioural model predicts outputs.
module tb_keypad_scan_reader;

  localparam int CLK_DIV = 4;
  localparam int DF      = 3;
  localparam int FRAME   = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready = 1'b0;
  logic        key_held;
  logic        overflow;
  logic [15:0] pressed = 16'h0;

  int vectors     = 0;
  int miscompares = 0;
  int ovf_pulses  = 0;

  // Behavioural model state (frame/streak view of the keypad)
  int cyc;
  bit m_held, m_valid, m_ovf, m_confirm, m_accept;
  int m_code, streak_code, streak_len, rel_len, m_res;

  keypad_scan_reader #(.CLK_DIV(CLK_DIV), .DEBOUNCE_FRAMES(DF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Key matrix: a row reads low when a pressed key sits on the driven column
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
    end
  end

  function automatic int frame_result(input logic [15:0] p);
    int n;
    int low;
    n   = 0;
    low = -1;
    for (int i = 0; i < 16; i++) begin
      if (p[i]) begin
        n++;
        if (low < 0) low = i;
      end
    end
`ifdef KEYPAD_MULTI_KEY_REJECT_EN
    if (n > 1) low = -1;
`endif
    return low;
  endfunction

  // Model: every FRAME cycles one frame result; a press is DF identical
  // consecutive codes while not held, a release is DF consecutive empty frames.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_held = 0; m_valid = 0; m_ovf = 0; m_code = 0;
      streak_code = 0; streak_len = 0; rel_len = 0;
    end else begin
      cyc++;
      m_ovf     = 0;
      m_confirm = 0;
      m_accept  = m_valid && key_ready;
      if (cyc % FRAME == 0) begin
        m_res = frame_result(pressed);
        if (!m_held) begin
          if (m_res >= 0 && streak_len > 0 && m_res == streak_code) streak_len++;
          else if (m_res >= 0 && streak_len == 0) begin
            streak_code = m_res;
            streak_len  = 1;
          end else streak_len = 0;
          if (streak_len == DF) begin
            m_confirm  = 1;
            m_held     = 1;
            streak_len = 0;
            rel_len    = 0;
          end
        end else begin
          if (m_res < 0) begin
            rel_len++;
            if (rel_len == DF) begin
              m_held  = 0;
              rel_len = 0;
            end
          end else rel_len = 0;
        end
      end
      if (m_confirm) begin
        if (m_valid && !m_accept) m_ovf = 1;
        else begin
          m_valid = 1;
          m_code  = streak_code;
        end
      end else if (m_accept) m_valid = 0;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle, 1 time unit after the rising edge
  always @(posedge clk) begin
    #1;
    checkOutput("col_n",     col_n,     int'(~(4'b0001 << ((cyc / CLK_DIV) % 4))) & 4'hF);
    checkOutput("key_valid", key_valid, m_valid);
    checkOutput("key_code",  key_code,  m_code);
    checkOutput("key_held",  key_held,  m_held);
    checkOutput("overflow",  overflow,  m_ovf);
    if (overflow) ovf_pulses++;
  end

  task automatic applyStimulus(input int n, input logic [15:0] p, input int ready_pct);
    for (int f = 0; f < n; f++) begin
      pressed = p;
      repeat (FRAME) begin
        @(negedge clk);
        key_ready = ($urandom_range(99) < ready_pct);
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] randKeys();
    int sel;
    sel = $urandom_range(9);
    if (sel < 3) return 16'h0;
    if (sel < 8) return 16'h1 << $urandom_range(15);
    return (16'h1 << $urandom_range(15)) | (16'h1 << $urandom_range(15));
  endfunction

  initial begin
    int ovf_before;
    logic [15:0] p;
    key_ready = 1'b0;
    pressed   = 16'h0;
    doReset();
    // Reset state pinned
    checkOutput("rst_col_n", col_n, 4'b1110);
    checkOutput("rst_valid", key_valid, 0);
    checkOutput("rst_held",  key_held, 0);
    checkOutput("rst_code",  key_code, 0);

    applyStimulus(2, 16'h0, 0);
    checkOutput("idle_valid", key_valid, 0);

    // Row1/col2 held three frames, nobody accepting
    applyStimulus(3, 16'h0040, 0);
    checkOutput("press6_valid", key_valid, 1);
    checkOutput("press6_code",  key_code, 4'h6);
    applyStimulus(1, 16'h0040, 0);
    checkOutput("press6_stays", key_valid, 1);

    // Release, then press 0xF while 6 still pending
    applyStimulus(3, 16'h0, 0);
    checkOutput("release_held", key_held, 0);
    ovf_before = ovf_pulses;
    applyStimulus(3, 16'h8000, 0);
    checkOutput("ovf_pulses", ovf_pulses - ovf_before, 1);
    checkOutput("ovf_code",   key_code, 4'h6);
    checkOutput("ovf_held",   key_held, 1);

    applyStimulus(3, 16'h0, 100);
    checkOutput("drain_valid", key_valid, 0);

    // Bouncing key never confirms
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 16'h0008, 0);
      applyStimulus(1, 16'h0, 0);
    end
    checkOutput("bounce_valid", key_valid, 0);
    checkOutput("bounce_held",  key_held, 0);

    // Reset in the middle of a debounce
    applyStimulus(1, 16'h0020, 0);
    pressed = 16'h0020;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_col",   col_n, 4'b1110);
    checkOutput("midrst_valid", key_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2, 16'h0020, 0);
    checkOutput("postrst_valid", key_valid, 0);
    applyStimulus(1, 16'h0020, 0);
    checkOutput("postrst_valid3", key_valid, 1);
    checkOutput("postrst_code",   key_code, 4'h5);

    applyStimulus(3, 16'h0, 100);

    // Chord of keys 0x1 and 0x8
    applyStimulus(3, 16'h0102, 0);
`ifdef KEYPAD_MULTI_KEY_REJECT_EN
    checkOutput("chord_valid", key_valid, 0);
`else
    checkOutput("chord_valid", key_valid, 1);
    checkOutput("chord_code",  key_code, 4'h1);
`endif
    applyStimulus(3, 16'h0, 100);

    // Randomized frames with sticky keys so presses can confirm
    p = 16'h0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(9) < 4) p = randKeys();
      applyStimulus(1, p, 30);
    end
    applyStimulus(4, 16'h0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
